// File: rtl/divider_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// divider_arbiter : round-robin front end sharing one divider among requesters
// Optional: DIV_ZERO_BYPASS_EN completes zero-divisor jobs without the divider
// Revision: 1.0
// ---------------------------------------------------------------------------
module divider_arbiter #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ-1:0]       req_sign,
  input  logic [NUM_REQ*WIDTH-1:0] req_dividend,
  input  logic [NUM_REQ*WIDTH-1:0] req_divisor,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic [WIDTH-1:0]         result_quotient,
  output logic [WIDTH-1:0]         result_remainder,
  output logic                     div_zero,
  output logic                     busy,
  output logic                     div_start,
  output logic                     div_sign,
  output logic [WIDTH-1:0]         div_dividend,
  output logic [WIDTH-1:0]         div_divisor,
  input  logic [WIDTH-1:0]         div_quotient,
  input  logic [WIDTH-1:0]         div_remainder,
  input  logic                     div_ready
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               state_q;
  logic [PTR_W-1:0]     rr_ptr_q;
  logic [PTR_W-1:0]     owner_q;
  logic [NUM_REQ-1:0]   grant_q;
  logic [NUM_REQ-1:0]   done_q;
  logic [WIDTH-1:0]     quot_q;
  logic [WIDTH-1:0]     rem_q;
  logic                 busy_q;
  logic                 start_q;
  logic                 sign_q;
  logic [WIDTH-1:0]     dvd_q;
  logic [WIDTH-1:0]     dvs_q;

  logic [PTR_W-1:0]     sel_d;
  logic                 any_req;
  logic [WIDTH-1:0]     sel_dvd;
  logic [WIDTH-1:0]     sel_dvs;
  logic [NUM_REQ-1:0]   sel_onehot;
  logic [NUM_REQ-1:0]   owner_onehot;
  logic [PTR_W-1:0]     rr_ptr_d;

  // Scan from the highest offset down so the nearest requester at/after rr_ptr wins.
  always_comb begin
    sel_d   = '0;
    any_req = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      logic [PTR_W-1:0] idx;
      idx = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (req[idx]) begin
        sel_d   = idx;
        any_req = 1'b1;
      end
    end
  end

  assign sel_dvd      = req_dividend[int'(sel_d)*WIDTH +: WIDTH];
  assign sel_dvs      = req_divisor[int'(sel_d)*WIDTH +: WIDTH];
  assign sel_onehot   = {{(NUM_REQ-1){1'b0}}, 1'b1} << sel_d;
  assign owner_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q;
  assign rr_ptr_d     = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

`ifdef DIV_ZERO_BYPASS_EN
  logic bypass_q;
  logic zero_q;
  assign div_zero = zero_q;
`else
  assign div_zero = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      quot_q   <= '0;
      rem_q    <= '0;
      busy_q   <= 1'b0;
      start_q  <= 1'b0;
      sign_q   <= 1'b0;
      dvd_q    <= '0;
      dvs_q    <= '0;
`ifdef DIV_ZERO_BYPASS_EN
      bypass_q <= 1'b0;
      zero_q   <= 1'b0;
`endif
    end else begin
      grant_q <= '0;
      done_q  <= '0;
      start_q <= 1'b0;
`ifdef DIV_ZERO_BYPASS_EN
      zero_q  <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (any_req) begin
            owner_q <= sel_d;
            grant_q <= sel_onehot;
            dvd_q   <= sel_dvd;
            dvs_q   <= sel_dvs;
            sign_q  <= req_sign[sel_d];
            busy_q  <= 1'b1;
            state_q <= S_ISSUE;
`ifdef DIV_ZERO_BYPASS_EN
            bypass_q <= (sel_dvs == '0);
            start_q  <= (sel_dvs != '0);
`else
            start_q  <= 1'b1;
`endif
          end
        end
        S_ISSUE: begin
`ifdef DIV_ZERO_BYPASS_EN
          // A zero-divisor job never reaches the divider; its result is synthesized here.
          if (bypass_q) begin
            quot_q  <= '1;
            rem_q   <= dvd_q;
            zero_q  <= 1'b1;
            done_q  <= owner_onehot;
            state_q <= S_DONE;
          end else begin
            state_q <= S_WAIT;
          end
`else
          state_q <= S_WAIT;
`endif
        end
        S_WAIT: begin
          if (div_ready) begin
            quot_q  <= div_quotient;
            rem_q   <= div_remainder;
            done_q  <= owner_onehot;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          rr_ptr_q <= rr_ptr_d;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign grant            = grant_q;
  assign done             = done_q;
  assign result_quotient  = quot_q;
  assign result_remainder = rem_q;
  assign busy             = busy_q;
  assign div_start        = start_q;
  assign div_sign         = sign_q;
  assign div_dividend     = dvd_q;
  assign div_divisor      = dvs_q;

endmodule
`default_nettype wire

// File: tb/tb_divider_arbiter.sv
`default_nettype none
// tb_divider_arbiter : scoreboard bench for divider_arbiter with a behavioural divider.
module tb_divider_arbiter;
  localparam int WIDTH   = 8;
  localparam int NUM_REQ = 4;
  localparam int PTR_W   = 2;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ-1:0]       req_sign;
  logic [NUM_REQ*WIDTH-1:0] req_dividend;
  logic [NUM_REQ*WIDTH-1:0] req_divisor;
  logic [NUM_REQ-1:0]       grant;
  logic [NUM_REQ-1:0]       done;
  logic [WIDTH-1:0]         result_quotient;
  logic [WIDTH-1:0]         result_remainder;
  logic                     div_zero;
  logic                     busy;
  logic                     div_start;
  logic                     div_sign;
  logic [WIDTH-1:0]         div_dividend;
  logic [WIDTH-1:0]         div_divisor;
  logic [WIDTH-1:0]         div_quotient;
  logic [WIDTH-1:0]         div_remainder;
  logic                     div_ready;

  always #5 clk = ~clk;

  divider_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) dut (
    .clk(clk), .reset(reset), .req(req), .req_sign(req_sign),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .grant(grant), .done(done), .result_quotient(result_quotient),
    .result_remainder(result_remainder), .div_zero(div_zero), .busy(busy),
    .div_start(div_start), .div_sign(div_sign), .div_dividend(div_dividend),
    .div_divisor(div_divisor), .div_quotient(div_quotient),
    .div_remainder(div_remainder), .div_ready(div_ready)
  );

  typedef struct { int owner; bit start; } gexp_t;
  typedef struct { int owner; logic [7:0] q; logic [7:0] r; bit z; } dexp_t;

  gexp_t gq[$];
  dexp_t dq[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int grant_cnt = 0;
  int done_cnt = 0;
  int last_grant_cyc = -1;
  int last_done_cyc = -1;
  bit chk_b2b = 1'b0;
  int lat_cfg = 3;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void div_model(input bit s, input logic [7:0] a, input logic [7:0] b,
                                    output logic [7:0] q, output logic [7:0] r);
    int sa, sb;
    if (b == 8'd0) begin
      q = 8'hFF;
      r = a;
      return;
    end
    if (s) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
    end else begin
      sa = int'(a);
      sb = int'(b);
    end
    q = 8'(sa / sb);
    r = 8'(sa % sb);
  endfunction

  // Behavioural divider: answers lat_cfg cycles after it samples div_start.
  initial begin
    logic [7:0] a, b, q, r;
    bit s;
    div_ready = 1'b0;
    div_quotient = '0;
    div_remainder = '0;
    forever begin
      @(posedge clk);
      if (div_start === 1'b1) begin
        a = div_dividend;
        b = div_divisor;
        s = div_sign;
        repeat (lat_cfg) @(posedge clk);
        #1;
        div_model(s, a, b, q, r);
        div_quotient = q;
        div_remainder = r;
        div_ready = 1'b1;
        @(posedge clk);
        #1 div_ready = 1'b0;
      end
    end
  end

  // Scoreboard monitor
  initial begin
    gexp_t g;
    dexp_t d;
    forever begin
      @(negedge clk);
      if (reset === 1'b0) begin
        if (grant !== '0) begin
          checks++;
          if (gq.size() == 0) begin
            errors++;
            $display("FAIL grant_unexpected: got %b, expected none", grant);
          end else begin
            g = gq.pop_front();
            if (grant !== (4'b0001 << g.owner) || div_start !== g.start) begin
              errors++;
              $display("FAIL grant: got grant=%b start=%b, expected grant=%b start=%b",
                       grant, div_start, 4'b0001 << g.owner, g.start);
            end
          end
          if (chk_b2b && last_done_cyc >= 0) begin
            checks++;
            if (cyc - last_done_cyc != 2) begin
              errors++;
              $display("FAIL back_to_back: got gap %0d, expected 2", cyc - last_done_cyc);
            end
          end
          grant_cnt++;
          last_grant_cyc = cyc;
        end
        if (done !== '0) begin
          checks++;
          if (dq.size() == 0) begin
            errors++;
            $display("FAIL done_unexpected: got %b, expected none", done);
          end else begin
            d = dq.pop_front();
            if (done !== (4'b0001 << d.owner) || result_quotient !== d.q ||
                result_remainder !== d.r || div_zero !== d.z) begin
              errors++;
              $display("FAIL done: got done=%b q=%h r=%h z=%b, expected done=%b q=%h r=%h z=%b",
                       done, result_quotient, result_remainder, div_zero,
                       4'b0001 << d.owner, d.q, d.r, d.z);
            end
          end
          done_cnt++;
          last_done_cyc = cyc;
        end
        if (div_start === 1'b1 && grant === '0) begin
          errors++;
          $display("FAIL start_without_grant: got div_start=1, expected 0");
        end
      end
    end
  end

  task automatic drive_req(input int idx, input bit s, input logic [7:0] a, input logic [7:0] b);
    req_sign[idx] = s;
    req_dividend[idx*WIDTH +: WIDTH] = a;
    req_divisor[idx*WIDTH +: WIDTH] = b;
    req[idx] = 1'b1;
  endtask

  task automatic push_job(input int idx, input bit s, input logic [7:0] a, input logic [7:0] b);
    gexp_t g;
    dexp_t d;
    logic [7:0] q, r;
    div_model(s, a, b, q, r);
    g.owner = idx; g.start = 1'b1;
    d.owner = idx; d.q = q; d.r = r; d.z = 1'b0;
    gq.push_back(g);
    dq.push_back(d);
  endtask

  task automatic wait_grants(input int target, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk); #1;
      if (grant_cnt >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk); #1;
      if (gq.size() == 0 && dq.size() == 0 && busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req = '0; req_sign = '0; req_dividend = '0; req_divisor = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({grant, done, busy, div_start, div_zero} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b, expected 0", {grant, done, busy, div_start, div_zero});
    end
    checks++;
    if ({result_quotient, result_remainder, div_dividend, div_divisor, div_sign} !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h, expected 0",
               {result_quotient, result_remainder, div_dividend, div_divisor, div_sign});
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_round_robin();
    bit ok;
    int g0, d0;
    lat_cfg = 2;
    g0 = grant_cnt;
    d0 = done_cnt;
    last_done_cyc = -1;
    chk_b2b = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_sign[i] = (i == 2);
      req_dividend[i*WIDTH +: WIDTH] = 8'(i * 37 + 20);
      req_divisor[i*WIDTH +: WIDTH] = 8'(i + 3);
    end
    for (int j = 0; j < 5; j++)
      push_job(j % NUM_REQ, (j % NUM_REQ) == 2, 8'((j % NUM_REQ) * 37 + 20), 8'((j % NUM_REQ) + 3));
    req = 4'b1111;
    wait_grants(g0 + 5, ok);
    req = '0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rr_grants: got %0d grants, expected 5", grant_cnt - g0);
    end
    wait_drain(ok);
    chk_b2b = 1'b0;
    checks++;
    if (!ok || done_cnt - d0 != 5) begin
      errors++;
      $display("FAIL rr_dones: got %0d dones, expected 5", done_cnt - d0);
    end
  endtask

  task automatic test_unsigned();
    bit ok;
    int g0;
    lat_cfg = 4;
    g0 = grant_cnt;
    push_job(1, 1'b0, 8'd100, 8'd7);
    drive_req(1, 1'b0, 8'd100, 8'd7);
    wait_grants(g0 + 1, ok);
    req = '0;
    wait_drain(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL unsigned_timeout: got busy=%b, expected drained", busy);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (result_quotient !== 8'd14 || result_remainder !== 8'd2) begin
      errors++;
      $display("FAIL result_hold: got q=%0d r=%0d, expected q=14 r=2", result_quotient, result_remainder);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int g0, d0;
    gexp_t g;
    lat_cfg = 6;
    g0 = grant_cnt;
    g.owner = 2; g.start = 1'b1;
    gq.push_back(g);
    drive_req(2, 1'b0, 8'd50, 8'd5);
    wait_grants(g0 + 1, ok);
    req = '0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({grant, done, busy, div_start, div_zero, result_quotient, result_remainder,
         div_dividend, div_divisor, div_sign} !== '0) begin
      errors++;
      $display("FAIL reset_async: got busy=%b q=%h dvd=%h dvs=%h, expected all 0",
               busy, result_quotient, div_dividend, div_divisor);
    end
    d0 = done_cnt;
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (done_cnt != d0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stale_ready: got %0d dones busy=%b, expected 0 dones busy=0", done_cnt - d0, busy);
    end
    lat_cfg = 3;
    g0 = grant_cnt;
    push_job(2, 1'b0, 8'd50, 8'd5);
    drive_req(2, 1'b0, 8'd50, 8'd5);
    wait_grants(g0 + 1, ok);
    req = '0;
    wait_drain(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL reset_recover: got busy=%b, expected drained", busy);
    end
  endtask

  task automatic test_rr_wrap();
    bit ok;
    int g0;
    g0 = grant_cnt;
    push_job(0, 1'b0, 8'd9, 8'd2);
    push_job(1, 1'b0, 8'd200, 8'd9);
    drive_req(0, 1'b0, 8'd9, 8'd2);
    drive_req(1, 1'b0, 8'd200, 8'd9);
    wait_grants(g0 + 2, ok);
    req = '0;
    wait_drain(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rr_wrap: got %0d grants, expected 2", grant_cnt - g0);
    end
  endtask

  task automatic test_signed();
    bit ok;
    int g0;
    dexp_t d;
    gexp_t g;
    g0 = grant_cnt;
    g.owner = 0; g.start = 1'b1;
    d.owner = 0; d.q = 8'hFD; d.r = 8'hFF; d.z = 1'b0;
    gq.push_back(g);
    dq.push_back(d);
    drive_req(0, 1'b1, 8'hF6, 8'd3);
    wait_grants(g0 + 1, ok);
    req = '0;
    wait_drain(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL signed_timeout: got busy=%b, expected drained", busy);
    end
  endtask

  task automatic test_div_zero();
    bit ok;
    int g0;
    dexp_t d;
    gexp_t g;
    g0 = grant_cnt;
    g.owner = 3;
    d.owner = 3; d.q = 8'hFF; d.r = 8'h55;
`ifdef DIV_ZERO_BYPASS_EN
    g.start = 1'b0; d.z = 1'b1;
`else
    g.start = 1'b1; d.z = 1'b0;
`endif
    gq.push_back(g);
    dq.push_back(d);
    drive_req(3, 1'b0, 8'h55, 8'h00);
    wait_grants(g0 + 1, ok);
    req = '0;
    wait_drain(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL zero_timeout: got busy=%b, expected drained", busy);
    end
`ifdef DIV_ZERO_BYPASS_EN
    checks++;
    if (last_done_cyc - last_grant_cyc != 1) begin
      errors++;
      $display("FAIL zero_latency: got %0d, expected 1", last_done_cyc - last_grant_cyc);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_unsigned();
    test_reset_mid();
    test_rr_wrap();
    test_signed();
    test_div_zero();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end
endmodule
`default_nettype wire
